load_store_unit: RTL and testbench

MEM-stage sequencer sitting directly upstream of the byte-addressed data memory in the 16-bit pipeline. It accepts one load/store request from the EX/MEM side with a valid/ready handshake and drives the memory's write-enable, read-enable, size, address and write-data inputs for a fixed number of access cycles. It captures the memory read data and presents exactly one registered writeback response per request to the MEM/WB side, again with a valid/ready handshake. Upstream stall is derived from req_ready.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/lsu_access_timer.sv | 36 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store sequencer: access sizes,
// FSM states, ACCESS_CYCLES limits and small request-decode helpers.
package lsu_pkg;

  localparam logic [1:0] SIZE_WORD    = 2'b00;
  localparam logic [1:0] SIZE_BYTE_ZX = 2'b01;
  localparam logic [1:0] SIZE_BYTE_SX = 2'b10;
  localparam logic [1:0] SIZE_RSVD    = 2'b11;

  localparam int ACCESS_CYCLES_MIN = 1;
  localparam int ACCESS_CYCLES_MAX = 4;
  // Wide enough to hold ACCESS_CYCLES_MAX-1
  localparam int TIMER_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic int clamp_cycles(input int n);
    if (n < ACCESS_CYCLES_MIN) return ACCESS_CYCLES_MIN;
    if (n > ACCESS_CYCLES_MAX) return ACCESS_CYCLES_MAX;
    return n;
  endfunction

  // The memory has no reserved encoding, so anything unknown becomes a word access
  function automatic logic [1:0] mem_size(input logic [1:0] size);
    case (size)
      SIZE_BYTE_ZX: return SIZE_BYTE_ZX;
      SIZE_BYTE_SX: return SIZE_BYTE_SX;
      default:      return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_fault(input logic [1:0] size, input logic addr_lsb);
    return ((size == SIZE_WORD) && addr_lsb) || (size == SIZE_RSVD);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback signals of the load/store unit.
// master = pipeline/memory side, slave = the load/store unit itself.
interface load_store_unit_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [REG_IDX_W-1:0] req_rd;

  logic                 mem_wr_en;
  logic                 mem_rd_en;
  logic [1:0]           mem_num_bytes;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;

  logic                 wb_valid;
  logic                 wb_ready;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic                 wb_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, req_rd,
    output mem_rdata, wb_ready,
    input  req_ready, mem_wr_en, mem_rd_en, mem_num_bytes, mem_addr, mem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, req_rd,
    input  mem_rdata, wb_ready,
    output req_ready, mem_wr_en, mem_rd_en, mem_num_bytes, mem_addr, mem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/lsu_access_timer.sv
// Loadable down-counter that sets how long the memory inputs are held;
// done_o is high while the count is zero.
module lsu_access_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of the byte-addressed data memory.
// Optional ALIGN_CHECK_EN: odd word and reserved-size requests fault without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int REG_IDX_W     = 3,
  parameter int ACCESS_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  // state  | meaning
  // IDLE   | no request held, ready for a new one
  // ACCESS | memory inputs driven from the captured request
  // RESP   | writeback response held until wb_ready

  localparam int                 CYC        = clamp_cycles(ACCESS_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CYC - 1);

  lsu_state_e           state_q;
  logic                 mem_wr_en_q;
  logic                 mem_rd_en_q;
  logic [1:0]           mem_size_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [REG_IDX_W-1:0] rd_q;

  logic                 wb_valid_q;
  logic                 wb_we_q;
  logic [REG_IDX_W-1:0] wb_rd_q;
  logic [DATA_W-1:0]    wb_data_q;
`ifdef ALIGN_CHECK_EN
  logic                 wb_err_q;
`endif

  logic req_ready;
  logic fault;
  logic timer_done;

  // A retiring response frees the unit in the same cycle
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.wb_ready);

`ifdef ALIGN_CHECK_EN
  assign fault = is_fault(bus.req_size, bus.req_addr[0]);
`else
  assign fault = 1'b0;
`endif

  lsu_access_timer #(
    .CNT_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (req_ready && bus.req_valid && !fault),
    .load_val_i (TIMER_LOAD),
    .en_i       (state_q == ACCESS),
    .done_o     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_size_q  <= SIZE_WORD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
`ifdef ALIGN_CHECK_EN
      wb_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          if (req_ready) begin
            wb_valid_q <= 1'b0;
`ifdef ALIGN_CHECK_EN
            wb_err_q   <= 1'b0;
`endif
            if (bus.req_valid) begin
              rd_q <= bus.req_rd;
              if (fault) begin
                state_q    <= RESP;
                wb_valid_q <= 1'b1;
                wb_we_q    <= 1'b0;
                wb_data_q  <= '0;
                wb_rd_q    <= bus.req_rd;
`ifdef ALIGN_CHECK_EN
                wb_err_q   <= 1'b1;
`endif
              end else begin
                state_q     <= ACCESS;
                mem_wr_en_q <= bus.req_we;
                mem_rd_en_q <= !bus.req_we;
                mem_size_q  <= mem_size(bus.req_size);
                mem_addr_q  <= bus.req_addr;
                mem_wdata_q <= bus.req_wdata;
              end
            end else begin
              state_q <= IDLE;
            end
          end
        end
        ACCESS: begin
          if (timer_done) begin
            state_q     <= RESP;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_size_q  <= SIZE_WORD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b1;
            wb_rd_q     <= rd_q;
            if (mem_wr_en_q) begin
              wb_we_q   <= 1'b0;
              wb_data_q <= '0;
            end else begin
              wb_we_q   <= 1'b1;
              wb_data_q <= bus.mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_wr_en     = mem_wr_en_q;
  assign bus.mem_rd_en     = mem_rd_en_q;
  assign bus.mem_num_bytes = mem_size_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_we         = wb_we_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
`ifdef ALIGN_CHECK_EN
  assign bus.wb_err        = wb_err_q;
`else
  assign bus.wb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (1 and 3 access cycles)
// against byte memory models, with a response scoreboard per instance.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic        we;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if b1 ();
  load_store_unit_if b3 ();

  load_store_unit #(.ACCESS_CYCLES(1)) u1 (.clk(clk), .reset(rst), .bus(b1));
  load_store_unit #(.ACCESS_CYCLES(3)) u3 (.clk(clk), .reset(rst), .bus(b3));

  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];
  logic [7:0] a1_lo, a1_hi, a3_lo, a3_hi;
  assign a1_lo = b1.mem_addr[7:0];
  assign a1_hi = a1_lo + 8'd1;
  assign a3_lo = b3.mem_addr[7:0];
  assign a3_hi = a3_lo + 8'd1;

  function automatic logic [7:0] preset(input int i);
    case (i)
      1: return 8'd1;
      2: return 8'd2;
      3: return 8'd3;
      4: return 8'd3;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [15:0] rd_model(input logic [7:0] lo, input logic [7:0] hi,
                                           input logic [1:0] sz);
    case (sz)
      SIZE_BYTE_ZX: return {8'h00, lo};
      SIZE_BYTE_SX: return {{8{lo[7]}}, lo};
      default:      return {hi, lo};
    endcase
  endfunction

  always_comb b1.mem_rdata = rd_model(mem1[a1_lo], mem1[a1_hi], b1.mem_num_bytes);
  always_comb b3.mem_rdata = rd_model(mem3[a3_lo], mem3[a3_hi], b3.mem_num_bytes);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= preset(i);
        mem3[i] <= preset(i);
      end
    end else begin
      if (b1.mem_wr_en) begin
        mem1[a1_lo] <= b1.mem_wdata[7:0];
        if (b1.mem_num_bytes == SIZE_WORD) mem1[a1_hi] <= b1.mem_wdata[15:8];
      end
      if (b3.mem_wr_en) begin
        mem3[a3_lo] <= b3.mem_wdata[7:0];
        if (b3.mem_num_bytes == SIZE_WORD) mem3[a3_hi] <= b3.mem_wdata[15:8];
      end
    end
  end

  exp_t q1[$];
  exp_t q3[$];
  int tests = 0;
  int fails = 0;
  int wr3_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [2:0] rd, input logic [15:0] data,
                              input logic err);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err;
    return e;
  endfunction

  // Samples just before the active edge: a valid&ready here retires at that edge
  task automatic mon();
    exp_t e;
    if (b1.wb_valid && b1.wb_ready) begin
      if (q1.size() == 0) chk("u1_unexpected_wb", 32'(b1.wb_valid), 32'd0);
      else begin
        e = q1.pop_front();
        chk("u1_wb_data", 32'(b1.wb_data), 32'(e.data));
        chk("u1_wb_we",   32'(b1.wb_we),   32'(e.we));
        chk("u1_wb_rd",   32'(b1.wb_rd),   32'(e.rd));
        chk("u1_wb_err",  32'(b1.wb_err),  32'(e.err));
      end
    end
    if (b3.wb_valid && b3.wb_ready) begin
      if (q3.size() == 0) chk("u3_unexpected_wb", 32'(b3.wb_valid), 32'd0);
      else begin
        e = q3.pop_front();
        chk("u3_wb_data", 32'(b3.wb_data), 32'(e.data));
        chk("u3_wb_we",   32'(b3.wb_we),   32'(e.we));
        chk("u3_wb_rd",   32'(b3.wb_rd),   32'(e.rd));
        chk("u3_wb_err",  32'(b3.wb_err),  32'(e.err));
      end
    end
    if (b3.mem_wr_en) wr3_cnt++;
  endtask

  task automatic tick();
    #1;
    mon();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic req(input int u, input logic we, input logic [1:0] sz, input logic [15:0] a,
                     input logic [15:0] wd, input logic [2:0] rd, input bit push, input exp_t e);
    logic rdy;
    if (u == 1) begin
      if (push) q1.push_back(e);
      b1.req_valid = 1'b1; b1.req_we = we; b1.req_size = sz;
      b1.req_addr = a; b1.req_wdata = wd; b1.req_rd = rd;
    end else begin
      if (push) q3.push_back(e);
      b3.req_valid = 1'b1; b3.req_we = we; b3.req_size = sz;
      b3.req_addr = a; b3.req_wdata = wd; b3.req_rd = rd;
    end
    #1;
    rdy = (u == 1) ? b1.req_ready : b3.req_ready;
    for (int n = 0; n < 20 && !rdy; n++) begin
      tick();
      rdy = (u == 1) ? b1.req_ready : b3.req_ready;
    end
    chk("req_ready_wait", 32'(rdy), 32'd1);
    tick();
    if (u == 1) b1.req_valid = 1'b0;
    else        b3.req_valid = 1'b0;
  endtask

  task automatic drain(input int u);
    int sz;
    sz = (u == 1) ? q1.size() : q3.size();
    for (int n = 0; n < 30 && sz != 0; n++) begin
      tick();
      sz = (u == 1) ? q1.size() : q3.size();
    end
    chk("drain_queue_empty", 32'(sz), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_size = 2'b00; b1.req_addr = '0;
    b1.req_wdata = '0; b1.req_rd = '0; b1.wb_ready = 1'b1;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_size = 2'b00; b3.req_addr = '0;
    b3.req_wdata = '0; b3.req_rd = '0; b3.wb_ready = 1'b1;

    // Reset values
    @(negedge clk); #1;
    chk("rst_req_ready",  32'(b1.req_ready), 32'd1);
    chk("rst_wb_valid",   32'(b1.wb_valid),  32'd0);
    chk("rst_mem_wr_en",  32'(b1.mem_wr_en), 32'd0);
    chk("rst_mem_rd_en",  32'(b1.mem_rd_en), 32'd0);
    chk("rst_mem_addr",   32'(b1.mem_addr),  32'd0);
    chk("rst_wb_data",    32'(b1.wb_data),   32'd0);
    chk("rst_wb_err",     32'(b1.wb_err),    32'd0);
    chk("rst_u3_ready",   32'(b3.req_ready), 32'd1);
    tick(); tick();
    mem_init = 1'b0;
    rst = 1'b0;
    tick();

    // Load word at 1 (odd): faults only with the alignment check
`ifdef ALIGN_CHECK_EN
    req(1, 1'b0, SIZE_WORD, 16'h0001, 16'h0, 3'd5, 1'b1, mk(1'b0, 3'd5, 16'h0000, 1'b1));
    chk("t1_wb_valid_n1",  32'(b1.wb_valid),  32'd1);
    chk("t1_no_rd_en",     32'(b1.mem_rd_en), 32'd0);
    chk("t1_wb_err",       32'(b1.wb_err),    32'd1);
`else
    req(1, 1'b0, SIZE_WORD, 16'h0001, 16'h0, 3'd5, 1'b1, mk(1'b1, 3'd5, 16'h0201, 1'b0));
    chk("t1_mem_rd_en",    32'(b1.mem_rd_en), 32'd1);
    chk("t1_mem_addr",     32'(b1.mem_addr),  32'h0001);
    chk("t1_wb_valid_lo",  32'(b1.wb_valid),  32'd0);
    tick();
    chk("t1_wb_valid_hi",  32'(b1.wb_valid),  32'd1);
    chk("t1_rd_en_off",    32'(b1.mem_rd_en), 32'd0);
`endif
    drain(1);

    req(1, 1'b0, SIZE_BYTE_ZX, 16'h0003, 16'h0, 3'd1, 1'b1, mk(1'b1, 3'd1, 16'h0003, 1'b0));
    drain(1);

    // Store then read back with sign and zero extension
    req(1, 1'b1, SIZE_WORD, 16'h0010, 16'h80A5, 3'd2, 1'b1, mk(1'b0, 3'd2, 16'h0000, 1'b0));
    chk("st_mem_wdata", 32'(b1.mem_wdata), 32'h80A5);
    drain(1);
    req(1, 1'b0, SIZE_BYTE_SX, 16'h0011, 16'h0, 3'd3, 1'b1, mk(1'b1, 3'd3, 16'hFF80, 1'b0));
    drain(1);
    req(1, 1'b0, SIZE_BYTE_ZX, 16'h0011, 16'h0, 3'd4, 1'b1, mk(1'b1, 3'd4, 16'h0080, 1'b0));
    drain(1);

    // Reserved size
`ifdef ALIGN_CHECK_EN
    req(1, 1'b0, SIZE_RSVD, 16'h0002, 16'h0, 3'd6, 1'b1, mk(1'b0, 3'd6, 16'h0000, 1'b1));
    chk("rsvd_no_rd_en", 32'(b1.mem_rd_en), 32'd0);
`else
    req(1, 1'b0, SIZE_RSVD, 16'h0002, 16'h0, 3'd6, 1'b1, mk(1'b1, 3'd6, 16'h0302, 1'b0));
    chk("rsvd_as_word", 32'(b1.mem_num_bytes), 32'(SIZE_WORD));
`endif
    drain(1);

    // Word at 0xFFFF wraps to 0x0000
`ifdef ALIGN_CHECK_EN
    req(1, 1'b1, SIZE_WORD, 16'hFFFF, 16'hBEEF, 3'd0, 1'b1, mk(1'b0, 3'd0, 16'h0000, 1'b1));
    chk("wrap_st_no_wr", 32'(b1.mem_wr_en), 32'd0);
    drain(1);
    req(1, 1'b0, SIZE_WORD, 16'hFFFF, 16'h0, 3'd7, 1'b1, mk(1'b0, 3'd7, 16'h0000, 1'b1));
`else
    req(1, 1'b1, SIZE_WORD, 16'hFFFF, 16'hBEEF, 3'd0, 1'b1, mk(1'b0, 3'd0, 16'h0000, 1'b0));
    chk("wrap_st_addr", 32'(b1.mem_addr), 32'hFFFF);
    drain(1);
    req(1, 1'b0, SIZE_WORD, 16'hFFFF, 16'h0, 3'd7, 1'b1, mk(1'b1, 3'd7, 16'hBEEF, 1'b0));
`endif
    drain(1);

    // Backpressure then back-to-back acceptance
    b1.wb_ready = 1'b0;
    req(1, 1'b0, SIZE_BYTE_ZX, 16'h0004, 16'h0, 3'd1, 1'b1, mk(1'b1, 3'd1, 16'h0003, 1'b0));
    tick();
    q1.push_back(mk(1'b1, 3'd2, 16'h0302, 1'b0));
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_size = SIZE_WORD;
    b1.req_addr = 16'h0002; b1.req_rd = 3'd2;
    for (int k = 0; k < 3; k++) begin
      chk("stall_wb_valid",  32'(b1.wb_valid),  32'd1);
      chk("stall_wb_data",   32'(b1.wb_data),   32'h0003);
      chk("stall_req_ready", 32'(b1.req_ready), 32'd0);
      tick();
    end
    b1.wb_ready = 1'b1;
    #1;
    chk("release_req_ready", 32'(b1.req_ready), 32'd1);
    tick();
    b1.req_valid = 1'b0;
    chk("b2b_rd_en",    32'(b1.mem_rd_en), 32'd1);
    chk("b2b_addr",     32'(b1.mem_addr),  32'h0002);
    chk("b2b_wb_valid", 32'(b1.wb_valid),  32'd0);
    drain(1);

    // Three access cycles
    wr3_cnt = 0;
    req(3, 1'b1, SIZE_WORD, 16'h0020, 16'h1234, 3'd0, 1'b1, mk(1'b0, 3'd0, 16'h0000, 1'b0));
    for (int k = 0; k < 3; k++) begin
      chk("ac3_wr_en",    32'(b3.mem_wr_en), 32'd1);
      chk("ac3_addr",     32'(b3.mem_addr),  32'h0020);
      chk("ac3_wdata",    32'(b3.mem_wdata), 32'h1234);
      chk("ac3_wb_valid", 32'(b3.wb_valid),  32'd0);
      tick();
    end
    chk("ac3_wr_en_off",   32'(b3.mem_wr_en), 32'd0);
    chk("ac3_wb_valid_n4", 32'(b3.wb_valid),  32'd1);
    chk("ac3_wr_cycles",   32'(wr3_cnt),      32'd3);
    drain(3);
    req(3, 1'b0, SIZE_WORD, 16'h0020, 16'h0, 3'd4, 1'b1, mk(1'b1, 3'd4, 16'h1234, 1'b0));
    drain(3);

    // Reset in the middle of a store
    wr3_cnt = 0;
    req(3, 1'b1, SIZE_WORD, 16'h0030, 16'hDEAD, 3'd1, 1'b0, mk(1'b0, 3'd0, 16'h0, 1'b0));
    chk("mid_wr_en", 32'(b3.mem_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr_en",     32'(b3.mem_wr_en),     32'd0);
    chk("rst_mid_rd_en",     32'(b3.mem_rd_en),     32'd0);
    chk("rst_mid_addr",      32'(b3.mem_addr),      32'd0);
    chk("rst_mid_wdata",     32'(b3.mem_wdata),     32'd0);
    chk("rst_mid_size",      32'(b3.mem_num_bytes), 32'd0);
    chk("rst_mid_wb_valid",  32'(b3.wb_valid),      32'd0);
    chk("rst_mid_req_ready", 32'(b3.req_ready),     32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("post_rst_no_write", 32'(wr3_cnt),        32'd0);
    chk("post_rst_mem30",    32'(mem3[8'h30]),    32'd0);
    chk("post_rst_mem31",    32'(mem3[8'h31]),    32'd0);
    chk("post_rst_wb_valid", 32'(b3.wb_valid),    32'd0);
    chk("q1_empty",          32'(q1.size()),      32'd0);
    chk("q3_empty",          32'(q3.size()),      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
